// File: rtl/alarm_sched_multi.sv
// alarm_sched_multi: NUM_ALARMS programmable alarm slots sharing one ring/snooze/stop controller.
// Define DAY_MASK_EN to add per-slot weekday masks (Day and LoadDays ports).
module alarm_sched_multi #(
  parameter int NUM_ALARMS  = 4,
  parameter int SNZ_CYCLES  = 60000,
  parameter int STOP_CYCLES = 3000,
  parameter int RING_CYCLES = 300000,
  parameter int MAX_SNOOZE  = 3,
  localparam int IDXW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int SCW  = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4:0]            Hour,
  input  logic [5:0]            Min,
  input  logic                  MinTick,
  input  logic                  Load,
  input  logic [IDXW-1:0]       LoadIdx,
  input  logic [4:0]            LoadHour,
  input  logic [5:0]            LoadMin,
  input  logic                  LoadEn,
`ifdef DAY_MASK_EN
  input  logic [2:0]            Day,
  input  logic [6:0]            LoadDays,
`endif
  input  logic                  EN_SNZ,
  input  logic                  EN_STOP,
  output logic                  Buzz,
  output logic                  Snoozing,
  output logic [IDXW-1:0]       ActiveIdx,
  output logic [SCW-1:0]        SnoozeCnt,
  output logic [NUM_ALARMS-1:0] AlarmOn
);

  localparam int SNW = (SNZ_CYCLES  > 1) ? $clog2(SNZ_CYCLES)  : 1;
  localparam int STW = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
  localparam int RTW = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;

  localparam logic [SNW-1:0] SNZ_LAST  = SNW'(SNZ_CYCLES - 1);
  localparam logic [STW-1:0] STOP_LAST = STW'(STOP_CYCLES - 1);
  localparam logic [RTW-1:0] RING_LAST = RTW'(RING_CYCLES - 1);
  localparam logic [SCW-1:0] SNZ_MAX   = SCW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  state_t                  state;
  logic [4:0]              slot_hour [NUM_ALARMS];
  logic [5:0]              slot_min  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]   slot_en;
`ifdef DAY_MASK_EN
  logic [6:0]              slot_days [NUM_ALARMS];
`endif

  logic [SNW-1:0]          snz_tmr;
  logic [STW-1:0]          stop_cnt;
  logic [RTW-1:0]          ring_tmr;
  logic                    snz_q;

  logic [NUM_ALARMS-1:0]   match;
  logic                    any_match;
  logic [IDXW-1:0]         match_idx;
  logic                    stop_done;
  logic                    snz_edge;
  logic                    snz_allowed;

  assign AlarmOn     = slot_en;
  assign stop_done   = EN_STOP && (stop_cnt == STOP_LAST);
  assign snz_edge    = EN_SNZ && !snz_q;
  assign snz_allowed = (SnoozeCnt < SNZ_MAX);

  // Compare against the slot registers as they stood before this edge, so a
  // Load in the same cycle as MinTick does not influence that tick.
  always_comb begin
    logic [7:0] days_ext;
    days_ext  = '0;
    match     = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = MinTick && slot_en[i] && (slot_hour[i] == Hour) && (slot_min[i] == Min);
`ifdef DAY_MASK_EN
      days_ext = {1'b0, slot_days[i]};
      if (!days_ext[Day]) match[i] = 1'b0;
`endif
    end
    any_match = |match;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (match[i]) match_idx = IDXW'(i);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hour[i] <= '0;
        slot_min[i]  <= '0;
`ifdef DAY_MASK_EN
        slot_days[i] <= 7'h7F;
`endif
      end
      slot_en   <= '0;
      state     <= ST_IDLE;
      Buzz      <= 1'b0;
      Snoozing  <= 1'b0;
      ActiveIdx <= '0;
      SnoozeCnt <= '0;
      snz_tmr   <= '0;
      stop_cnt  <= '0;
      ring_tmr  <= '0;
      snz_q     <= 1'b0;
    end else begin
      // Out-of-range LoadIdx matches no slot and is therefore dropped.
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (Load && (LoadIdx == IDXW'(i))) begin
          slot_hour[i] <= LoadHour;
          slot_min[i]  <= LoadMin;
          slot_en[i]   <= LoadEn;
`ifdef DAY_MASK_EN
          slot_days[i] <= LoadDays;
`endif
        end
      end
      snz_q <= EN_SNZ;

      case (state)
        ST_IDLE: begin
          snz_tmr  <= '0;
          stop_cnt <= '0;
          ring_tmr <= '0;
          if (any_match) begin
            state     <= ST_RING;
            Buzz      <= 1'b1;
            Snoozing  <= 1'b0;
            ActiveIdx <= match_idx;
            SnoozeCnt <= '0;
          end
        end

        ST_RING, ST_SNOOZE: begin
          if (!EN_STOP)                 stop_cnt <= '0;
          else if (stop_cnt != STOP_LAST) stop_cnt <= stop_cnt + STW'(1);

          if (stop_done) begin
            state     <= ST_IDLE;
            Buzz      <= 1'b0;
            Snoozing  <= 1'b0;
            SnoozeCnt <= '0;
            snz_tmr   <= '0;
            stop_cnt  <= '0;
            ring_tmr  <= '0;
          end else if (state == ST_RING) begin
            if (snz_edge && snz_allowed) begin
              state     <= ST_SNOOZE;
              Buzz      <= 1'b0;
              Snoozing  <= 1'b1;
              SnoozeCnt <= SnoozeCnt + SCW'(1);
              snz_tmr   <= '0;
            end else if (ring_tmr == RING_LAST) begin
              // Unattended too long: auto-off, ActiveIdx keeps the last event.
              state     <= ST_IDLE;
              Buzz      <= 1'b0;
              Snoozing  <= 1'b0;
              SnoozeCnt <= '0;
              snz_tmr   <= '0;
              stop_cnt  <= '0;
              ring_tmr  <= '0;
            end else begin
              ring_tmr <= ring_tmr + RTW'(1);
            end
          end else begin
            if (snz_tmr == SNZ_LAST) begin
              state    <= ST_RING;
              Buzz     <= 1'b1;
              Snoozing <= 1'b0;
              ring_tmr <= '0;
            end else begin
              snz_tmr <= snz_tmr + SNW'(1);
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          Buzz     <= 1'b0;
          Snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_sched_multi.sv
// Self-checking bench for alarm_sched_multi: directed scenarios plus randomized
// traffic compared against an event-level reference model.
`timescale 1ns/1ps
module tb_alarm_sched_multi;

  localparam int NA   = 4;
  localparam int SNZ  = 20;
  localparam int STP  = 16;
  localparam int RNG  = 60;
  localparam int MAXS = 3;
  localparam int IDXW = 2;
  localparam int SCW  = 2;

  localparam int M_IDLE   = 0;
  localparam int M_RING   = 1;
  localparam int M_SNOOZE = 2;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [4:0]      Hour;
  logic [5:0]      Min;
  logic            MinTick;
  logic            Load;
  logic [IDXW-1:0] LoadIdx;
  logic [4:0]      LoadHour;
  logic [5:0]      LoadMin;
  logic            LoadEn;
  logic [2:0]      Day;
  logic [6:0]      LoadDays;
  logic            EN_SNZ;
  logic            EN_STOP;
  logic            Buzz;
  logic            Snoozing;
  logic [IDXW-1:0] ActiveIdx;
  logic [SCW-1:0]  SnoozeCnt;
  logic [NA-1:0]   AlarmOn;

  int errors = 0;
  int checks = 0;

  alarm_sched_multi #(
    .NUM_ALARMS (NA),
    .SNZ_CYCLES (SNZ),
    .STOP_CYCLES(STP),
    .RING_CYCLES(RNG),
    .MAX_SNOOZE (MAXS)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Hour     (Hour),
    .Min      (Min),
    .MinTick  (MinTick),
    .Load     (Load),
    .LoadIdx  (LoadIdx),
    .LoadHour (LoadHour),
    .LoadMin  (LoadMin),
    .LoadEn   (LoadEn),
`ifdef DAY_MASK_EN
    .Day      (Day),
    .LoadDays (LoadDays),
`endif
    .EN_SNZ   (EN_SNZ),
    .EN_STOP  (EN_STOP),
    .Buzz     (Buzz),
    .Snoozing (Snoozing),
    .ActiveIdx(ActiveIdx),
    .SnoozeCnt(SnoozeCnt),
    .AlarmOn  (AlarmOn)
  );

  // Clock / reset
  initial forever #5 Clk = ~Clk;

  // Reference model: tracks alarm events in terms of elapsed cycles per phase.
  int            m_mode;
  int            m_idx;
  int            m_snz;
  int            m_ring_age;
  int            m_snz_age;
  int            m_hold;
  bit            m_prev_snz;
  int            m_hr [NA];
  int            m_mn [NA];
  logic [NA-1:0] m_en;
  logic [6:0]    m_days [NA];
  logic [IDXW-1:0] exp_q[$];
  logic [IDXW-1:0] act_q[$];

  always @(posedge Clk) begin : ref_model
    int hit;
    bit day_ok;
    if (Reset) begin
      m_mode = M_IDLE; m_idx = 0; m_snz = 0; m_ring_age = 0; m_snz_age = 0;
      m_hold = 0; m_prev_snz = 0; m_en = '0;
      for (int i = 0; i < NA; i++) begin m_hr[i] = 0; m_mn[i] = 0; m_days[i] = 7'h7F; end
    end else begin
      hit = -1;
      if (MinTick) begin
        for (int i = 0; i < NA; i++) begin
          day_ok = 1'b1;
`ifdef DAY_MASK_EN
          day_ok = (Day <= 3'd6) && m_days[i][Day];
`endif
          if (hit < 0 && m_en[i] && m_hr[i] == int'(Hour) && m_mn[i] == int'(Min) && day_ok) hit = i;
        end
      end
      if (m_mode == M_IDLE) begin
        if (hit >= 0) begin
          m_mode = M_RING; m_idx = hit; m_snz = 0; m_ring_age = 0; m_hold = 0;
          exp_q.push_back(IDXW'(hit));
        end
      end else begin
        m_hold = EN_STOP ? m_hold + 1 : 0;
        if (m_hold >= STP) begin
          m_mode = M_IDLE; m_snz = 0; m_hold = 0;
        end else if (m_mode == M_RING && EN_SNZ && !m_prev_snz && m_snz < MAXS) begin
          m_mode = M_SNOOZE; m_snz++; m_snz_age = 0;
        end else if (m_mode == M_RING) begin
          m_ring_age++;
          if (m_ring_age >= RNG) begin m_mode = M_IDLE; m_snz = 0; m_hold = 0; end
        end else begin
          m_snz_age++;
          if (m_snz_age >= SNZ) begin m_mode = M_RING; m_ring_age = 0; end
        end
      end
      m_prev_snz = EN_SNZ;
      if (Load && int'(LoadIdx) < NA) begin
        m_hr[LoadIdx] = int'(LoadHour); m_mn[LoadIdx] = int'(LoadMin);
        m_en[LoadIdx] = LoadEn; m_days[LoadIdx] = LoadDays;
      end
    end
  end

  // DUT-side event log: one entry each time the buzzer starts a new event.
  bit was_busy = 1'b0;
  always @(negedge Clk) begin
    if (Buzz === 1'b1 && !was_busy) act_q.push_back(ActiveIdx);
    was_busy = (Buzz === 1'b1) || (Snoozing === 1'b1);
  end

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic load_slot(input int idx, input int h, input int m, input bit en);
    Load = 1'b1; LoadIdx = IDXW'(idx); LoadHour = 5'(h); LoadMin = 6'(m); LoadEn = en;
    cyc(1);
    Load = 1'b0;
  endtask

  task automatic tick(input int h, input int m);
    Hour = 5'(h); Min = 6'(m); MinTick = 1'b1;
    cyc(1);
    MinTick = 1'b0;
  endtask

  task automatic hold_stop(input int n);
    EN_STOP = 1'b1;
    cyc(n);
    EN_STOP = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    checks++; if (Buzz !== 1'b0) begin errors++; $display("FAIL reset_buzz: got %0b expected 0", Buzz); end
    checks++; if (Snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing: got %0b expected 0", Snoozing); end
    checks++; if (ActiveIdx !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", ActiveIdx); end
    checks++; if (SnoozeCnt !== '0) begin errors++; $display("FAIL reset_snzcnt: got %0d expected 0", SnoozeCnt); end
    checks++; if (AlarmOn !== 4'b0000) begin errors++; $display("FAIL reset_alarmon: got %b expected 0000", AlarmOn); end
  endtask

  task automatic test_basic_ring();
    load_slot(2, 7, 30, 1'b1);
    checks++; if (AlarmOn !== 4'b0100) begin errors++; $display("FAIL basic_alarmon: got %b expected 0100", AlarmOn); end
    tick(7, 30);
    checks++; if (Buzz !== 1'b1) begin errors++; $display("FAIL basic_buzz: got %0b expected 1", Buzz); end
    checks++; if (ActiveIdx !== 2'd2) begin errors++; $display("FAIL basic_idx: got %0d expected 2", ActiveIdx); end
    checks++; if (SnoozeCnt !== 2'd0) begin errors++; $display("FAIL basic_snzcnt: got %0d expected 0", SnoozeCnt); end
    EN_STOP = 1'b1;
    cyc(STP - 1);
    checks++; if (Buzz !== 1'b1) begin errors++; $display("FAIL basic_stop_early: got %0b expected 1", Buzz); end
    cyc(1);
    EN_STOP = 1'b0;
    checks++; if (Buzz !== 1'b0) begin errors++; $display("FAIL basic_stop_done: got %0b expected 0", Buzz); end
  endtask

  task automatic test_priority();
    load_slot(1, 6, 0, 1'b1);
    load_slot(3, 6, 0, 1'b1);
    checks++; if (AlarmOn !== 4'b1110) begin errors++; $display("FAIL prio_alarmon: got %b expected 1110", AlarmOn); end
    tick(6, 0);
    checks++; if (ActiveIdx !== 2'd1) begin errors++; $display("FAIL prio_lowest: got %0d expected 1", ActiveIdx); end
    hold_stop(STP);
    load_slot(1, 6, 0, 1'b0);
    // Disable slot 3 in the very cycle its tick arrives: the tick still wins.
    Load = 1'b1; LoadIdx = 2'd3; LoadHour = 5'd6; LoadMin = 6'd0; LoadEn = 1'b0;
    tick(6, 0);
    Load = 1'b0;
    checks++; if (Buzz !== 1'b1) begin errors++; $display("FAIL prio_same_cycle_buzz: got %0b expected 1", Buzz); end
    checks++; if (ActiveIdx !== 2'd3) begin errors++; $display("FAIL prio_same_cycle_idx: got %0d expected 3", ActiveIdx); end
    checks++; if (AlarmOn !== 4'b0100) begin errors++; $display("FAIL prio_disabled: got %b expected 0100", AlarmOn); end
    hold_stop(STP);
    checks++; if (Buzz !== 1'b0) begin errors++; $display("FAIL prio_stopped: got %0b expected 0", Buzz); end
  endtask

  task automatic test_snooze();
    load_slot(0, 8, 15, 1'b1);
    tick(8, 15);
    checks++; if (ActiveIdx !== 2'd0) begin errors++; $display("FAIL snz_idx: got %0d expected 0", ActiveIdx); end
    for (int k = 1; k <= MAXS; k++) begin
      EN_SNZ = 1'b1; cyc(1); EN_SNZ = 1'b0;
      checks++; if (Snoozing !== 1'b1 || Buzz !== 1'b0) begin errors++; $display("FAIL snz_enter_%0d: got snoozing=%0b buzz=%0b expected 1 0", k, Snoozing, Buzz); end
      checks++; if (SnoozeCnt !== SCW'(k)) begin errors++; $display("FAIL snz_count_%0d: got %0d expected %0d", k, SnoozeCnt, k); end
      cyc(SNZ - 1);
      checks++; if (Snoozing !== 1'b1) begin errors++; $display("FAIL snz_hold_%0d: got %0b expected 1", k, Snoozing); end
      cyc(1);
      checks++; if (Buzz !== 1'b1 || Snoozing !== 1'b0) begin errors++; $display("FAIL snz_rering_%0d: got buzz=%0b snoozing=%0b expected 1 0", k, Buzz, Snoozing); end
    end
    EN_SNZ = 1'b1; cyc(1); EN_SNZ = 1'b0;
    checks++; if (Buzz !== 1'b1 || Snoozing !== 1'b0) begin errors++; $display("FAIL snz_limit: got buzz=%0b snoozing=%0b expected 1 0", Buzz, Snoozing); end
    checks++; if (SnoozeCnt !== SCW'(MAXS)) begin errors++; $display("FAIL snz_limit_cnt: got %0d expected %0d", SnoozeCnt, MAXS); end
    hold_stop(STP - 10);
    cyc(1);
    checks++; if (Buzz !== 1'b1) begin errors++; $display("FAIL stop_partial: got %0b expected 1", Buzz); end
    hold_stop(STP);
    checks++; if (Buzz !== 1'b0 || SnoozeCnt !== 2'd0) begin errors++; $display("FAIL stop_full: got buzz=%0b cnt=%0d expected 0 0", Buzz, SnoozeCnt); end
  endtask

  task automatic test_timeout();
    load_slot(1, 9, 0, 1'b1);
    tick(9, 0);
    cyc(5);
    tick(7, 30);
    checks++; if (ActiveIdx !== 2'd1 || Buzz !== 1'b1) begin errors++; $display("FAIL timeout_drop_match: got idx=%0d buzz=%0b expected 1 1", ActiveIdx, Buzz); end
    cyc(RNG - 7);
    checks++; if (Buzz !== 1'b1) begin errors++; $display("FAIL timeout_early: got %0b expected 1", Buzz); end
    cyc(1);
    checks++; if (Buzz !== 1'b0) begin errors++; $display("FAIL timeout_off: got %0b expected 0", Buzz); end
    checks++; if (ActiveIdx !== 2'd1) begin errors++; $display("FAIL timeout_idx_hold: got %0d expected 1", ActiveIdx); end
  endtask

  task automatic test_reset_mid_snooze();
    tick(8, 15);
    EN_SNZ = 1'b1; cyc(1); EN_SNZ = 1'b0;
    checks++; if (Snoozing !== 1'b1) begin errors++; $display("FAIL rst_snz_enter: got %0b expected 1", Snoozing); end
    cyc(3);
    Reset = 1'b1; cyc(1); Reset = 1'b0;
    checks++; if (Buzz !== 1'b0 || Snoozing !== 1'b0) begin errors++; $display("FAIL rst_snz_out: got buzz=%0b snoozing=%0b expected 0 0", Buzz, Snoozing); end
    checks++; if (ActiveIdx !== '0 || SnoozeCnt !== '0) begin errors++; $display("FAIL rst_snz_regs: got idx=%0d cnt=%0d expected 0 0", ActiveIdx, SnoozeCnt); end
    checks++; if (AlarmOn !== 4'b0000) begin errors++; $display("FAIL rst_snz_alarmon: got %b expected 0000", AlarmOn); end
  endtask

`ifdef DAY_MASK_EN
  task automatic test_day_mask();
    LoadDays = 7'b0000001;
    load_slot(0, 10, 10, 1'b1);
    LoadDays = 7'h7F;
    Day = 3'd1; tick(10, 10);
    checks++; if (Buzz !== 1'b0) begin errors++; $display("FAIL day_masked: got %0b expected 0", Buzz); end
    Day = 3'd0; tick(10, 10);
    checks++; if (Buzz !== 1'b1) begin errors++; $display("FAIL day_allowed: got %0b expected 1", Buzz); end
    hold_stop(STP);
    load_slot(1, 11, 11, 1'b1);
    Day = 3'd7; tick(11, 11);
    checks++; if (Buzz !== 1'b0) begin errors++; $display("FAIL day_invalid: got %0b expected 0", Buzz); end
    Day = 3'd0;
  endtask
`endif

  task automatic test_random();
    int stop_left;
    stop_left = 0;
    exp_q.delete();
    act_q.delete();
    for (int c = 0; c < 2000; c++) begin
      Reset    = ($urandom_range(0, 499) == 0);
      Load     = ($urandom_range(0, 9) == 0);
      LoadIdx  = IDXW'($urandom_range(0, NA - 1));
      LoadHour = 5'($urandom_range(6, 7));
      LoadMin  = 6'($urandom_range(0, 1));
      LoadEn   = ($urandom_range(0, 3) != 0);
`ifdef DAY_MASK_EN
      LoadDays = 7'($urandom_range(0, 127));
      Day      = 3'($urandom_range(0, 7));
`endif
      MinTick  = ($urandom_range(0, 5) == 0);
      Hour     = 5'($urandom_range(6, 7));
      Min      = 6'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) EN_SNZ = ~EN_SNZ;
      if (stop_left > 0) begin
        EN_STOP = 1'b1; stop_left--;
      end else begin
        EN_STOP = 1'b0;
        if ($urandom_range(0, 30) == 0) stop_left = $urandom_range(3, 20);
      end
      cyc(1);
      checks++; if (Buzz !== (m_mode == M_RING)) begin errors++; $display("FAIL rnd_buzz @%0d: got %0b expected %0b", c, Buzz, (m_mode == M_RING)); end
      checks++; if (Snoozing !== (m_mode == M_SNOOZE)) begin errors++; $display("FAIL rnd_snoozing @%0d: got %0b expected %0b", c, Snoozing, (m_mode == M_SNOOZE)); end
      checks++; if (ActiveIdx !== IDXW'(m_idx)) begin errors++; $display("FAIL rnd_idx @%0d: got %0d expected %0d", c, ActiveIdx, m_idx); end
      checks++; if (SnoozeCnt !== SCW'(m_snz)) begin errors++; $display("FAIL rnd_snzcnt @%0d: got %0d expected %0d", c, SnoozeCnt, m_snz); end
      checks++; if (AlarmOn !== m_en) begin errors++; $display("FAIL rnd_alarmon @%0d: got %b expected %b", c, AlarmOn, m_en); end
    end
    Reset = 1'b0; Load = 1'b0; MinTick = 1'b0; EN_SNZ = 1'b0;
    hold_stop(STP + 1);
    cyc(2);
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_event_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      logic [IDXW-1:0] e, a;
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL rnd_event_idx: got %0d expected %0d", a, e); end
    end
  endtask

  initial begin
    Reset = 1'b1; Hour = '0; Min = '0; MinTick = 1'b0; Load = 1'b0; LoadIdx = '0;
    LoadHour = '0; LoadMin = '0; LoadEn = 1'b0; Day = 3'd0; LoadDays = 7'h7F;
    EN_SNZ = 1'b0; EN_STOP = 1'b0;
    test_reset();
    test_basic_ring();
    test_priority();
    test_snooze();
    test_timeout();
    test_reset_mid_snooze();
`ifdef DAY_MASK_EN
    test_day_mask();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_sched_multi.md
Name: alarm_sched_multi

Overview:
Parametrised successor to the single-alarm set/snooze/stop control path. Holds NUM_ALARMS programmable alarm registers and compares them against the running time on each minute tick. One shared ring/snooze/stop state machine drives the buzzer. Snooze, stop-hold and ring-timeout durations and the snooze limit are parameters, not hard-wired decodes.

Parameters:
NUM_ALARMS, 4, number of alarm slots (>=1)
SNZ_CYCLES, 60000, clocks spent in snooze before re-ring (1 min at 1 kHz)
STOP_CYCLES, 3000, clocks EN_STOP must be held continuously to stop (3 s)
RING_CYCLES, 300000, clocks of unattended ringing before auto-off
MAX_SNOOZE, 3, snoozes allowed per alarm event
(derived) IDXW = max(1,clog2(NUM_ALARMS)); SCW = clog2(MAX_SNOOZE+1)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Hour  in  5  current hour, 0-23
Min  in  6  current minute, 0-59
MinTick  in  1  one-cycle pulse; Hour/Min just advanced
Load  in  1  write alarm slot LoadIdx this cycle
LoadIdx  in  IDXW  slot to write
LoadHour  in  5  alarm hour
LoadMin  in  6  alarm minute
LoadEn  in  1  alarm enable bit written with slot
EN_SNZ  in  1  snooze button, level
EN_STOP  in  1  stop button, level
Buzz  out  1  alarm sounding
Snoozing  out  1  in SNOOZE state
ActiveIdx  out  IDXW  slot that raised the current event
SnoozeCnt  out  SCW  snoozes used in current event
AlarmOn  out  NUM_ALARMS  per-slot enable bits

Behaviour:
- Reset (sync, Clk edge): all slots hour=0, min=0, enable=0; state IDLE; Buzz=0, Snoozing=0, ActiveIdx=0, SnoozeCnt=0; all timers and the EN_SNZ edge register =0. Reset mid-ring/snooze aborts silently.
- Load: slot registers update at the clock edge; AlarmOn reflects them the next cycle. LoadIdx >= NUM_ALARMS: write ignored.
- Match: slot i matches when enable_i, hour_i==Hour, min_i==Min, MinTick=1. Compare uses pre-edge register values (same-cycle Load does not affect that tick).
- States: IDLE, RING, SNOOZE; all outputs registered.
- IDLE: any match -> RING next cycle, ActiveIdx = lowest matching index, SnoozeCnt=0, ring timer=0. Buzz=1 in the cycle after MinTick.
- RING: Buzz=1. Ring timer increments each cycle.
  - EN_STOP held: stop counter increments; released: counter clears. Count reaches STOP_CYCLES-1 while held -> IDLE.
  - Rising edge of EN_SNZ (registered edge detect) with SnoozeCnt<MAX_SNOOZE -> SNOOZE, SnoozeCnt+1, snooze timer=0. At SnoozeCnt==MAX_SNOOZE the edge is ignored.
  - Ring timer reaches RING_CYCLES-1 -> IDLE (auto-off).
- SNOOZE: Buzz=0, Snoozing=1. Snooze timer reaches SNZ_CYCLES-1 -> RING, ring timer=0. Stop-hold also works in SNOOZE (-> IDLE). EN_SNZ ignored.
- Same-cycle priority: Reset > stop-complete > snooze edge > timeout.
- Matches in RING/SNOOZE are dropped (no queueing). Loading or disabling ActiveIdx mid-event does not end the event.
- Leaving to IDLE clears SnoozeCnt, Snoozing and all timers; ActiveIdx holds its last value.
- Timers saturate, never wrap; widths = clog2 of the respective parameter.

Optional Feature:
DAY_MASK_EN: adds input Day (3 bits, 0-6) and LoadDays (7 bits, written with Load). Per-slot 7-bit mask, reset 7'h7F. Match additionally requires mask_i[Day]; Day>6 never matches. Without the macro these ports and masks are absent and alarms fire every day.

Test Plan:
- Reset, load slot2 = 07:30 enabled; drive Hour=7, Min=30, MinTick pulse -> Buzz=1 next cycle, ActiveIdx=2, SnoozeCnt=0.
- Slots 1 and 3 both 06:00 enabled, tick -> ActiveIdx=1; tick with only slot3 enabled but Load disabling it in the same cycle -> still rings, ActiveIdx=3.
- Ringing, EN_SNZ rising edge -> Snoozing=1, Buzz=0, SnoozeCnt=1; after SNZ_CYCLES cycles -> Buzz=1. Fourth snooze edge with MAX_SNOOZE=3 -> ignored, Buzz stays 1.
- Hold EN_STOP STOP_CYCLES-10 cycles, release, hold again a full STOP_CYCLES -> first attempt no effect, second -> IDLE, Buzz=0, SnoozeCnt=0.
- No input for RING_CYCLES -> auto IDLE. Second matching tick while ringing -> ActiveIdx unchanged.
- Reset asserted mid-SNOOZE -> next cycle all outputs 0, AlarmOn=0. With DAY_MASK_EN: mask 7'b0000001, Day=1 -> no ring; Day=0 -> ring.
